wrresp_latency_channel: RTL and testbench



---
 rtl/ase_pkg.sv | 27 ++
 rtl/wrresp_lfsr32.sv | 26 ++
 rtl/wrresp_latency_channel.sv | 152 +++++++++++++++
 tb/tb_wrresp_latency_channel.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ase_pkg.sv
// rtl/ase_pkg.sv - shared types and header-field constants for the write-response channel
package ase_pkg;

  localparam int ASE_HDR_W = 61;
  localparam int ASE_CNT_W = 16;

  // Transaction type field and the WrFence encoding within it.
  localparam int TX_META_TYPE_HI = 60;
  localparam int TX_META_TYPE_LO = 57;
  localparam logic [3:0] ASE_TX1_WRFENCE = 4'h5;

  typedef enum logic [0:0] {
    ST_NORMAL      = 1'b0,
    ST_FENCE_DRAIN = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic                 valid;
    logic [ASE_HDR_W-1:0] meta;
    logic [ASE_CNT_W-1:0] countdown;
  } wr_slot_t;

  function automatic logic is_wrfence(input logic [ASE_HDR_W-1:0] meta);
    return meta[TX_META_TYPE_HI:TX_META_TYPE_LO] == ASE_TX1_WRFENCE;
  endfunction

endpackage

// File: rtl/wrresp_lfsr32.sv
// rtl/wrresp_lfsr32.sv - 32-bit Galois LFSR (x^32+x^22+x^2+x+1) with enable
module wrresp_lfsr32 #(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] value
);

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic [31:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? TAPS : 32'h0);
    end
  end

  // Latency draws use only the low bits; the upper half is folded out here.
  assign value = state[15:0];

endmodule

// File: rtl/wrresp_latency_channel.sv
// rtl/wrresp_latency_channel.sv - emulated-latency write-response generator with WrFence ordering
module wrresp_latency_channel
  import ase_pkg::*;
#(
  parameter int          HDR_WIDTH       = ASE_HDR_W,
  parameter int          DEPTH_BASE2     = 4,
  parameter int          FULL_THRESH     = 14,
  parameter int          LAT_MIN         = 4,
  parameter int          LAT_RANGE_BASE2 = 3,
  parameter logic [31:0] LFSR_SEED       = 32'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HDR_WIDTH-1:0] meta_in,
  input  logic                 write_en,
  output logic                 full,
  output logic [HDR_WIDTH-1:0] resp_meta_out,
  output logic                 resp_valid_out,
  output logic                 resp_is_fence,
  output logic                 empty,
  output logic                 overflow,
  output logic [31:0]          count
);

  localparam int DEPTH = 1 << DEPTH_BASE2;
  localparam int OCC_W = DEPTH_BASE2 + 1;
  localparam logic [ASE_CNT_W-1:0] LAT_MASK = ASE_CNT_W'((1 << LAT_RANGE_BASE2) - 1);

  wr_slot_t             slots [DEPTH];
  wr_state_e            state;
  logic [OCC_W-1:0]     occ;
  logic [HDR_WIDTH-1:0] fence_meta;
  logic [15:0]          lfsr_low;

  logic [DEPTH-1:0]     ready_vec;
  logic [DEPTH-1:0]     free_vec;
  logic [DEPTH_BASE2:0] win;
  logic [DEPTH_BASE2:0] alloc;
  logic                 win_found;
  logic [DEPTH_BASE2-1:0] win_idx;
  logic [DEPTH_BASE2-1:0] alloc_idx;
  logic                 accept;
  logic                 in_fence;
  logic                 acc_wr;
  logic                 acc_fence;
  logic                 fence_fire;
  logic [ASE_CNT_W-1:0] lat_load;

  // Returns {found, index} of the lowest set request bit.
  function automatic logic [DEPTH_BASE2:0] pick_lowest(input logic [DEPTH-1:0] req);
    logic [DEPTH_BASE2:0] r;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) r = {1'b1, DEPTH_BASE2'(i)};
    end
    return r;
  endfunction

  wrresp_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (acc_wr),
    .value (lfsr_low)
  );

  always_comb begin
    ready_vec = '0;
    free_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = slots[i].valid && (slots[i].countdown == '0);
      free_vec[i]  = !slots[i].valid;
    end
  end

  assign win       = pick_lowest(ready_vec);
  assign alloc     = pick_lowest(free_vec);
  assign win_found = win[DEPTH_BASE2];
  assign win_idx   = win[DEPTH_BASE2-1:0];
  assign alloc_idx = alloc[DEPTH_BASE2-1:0];

  assign accept    = write_en && (occ < OCC_W'(DEPTH)) && (state == ST_NORMAL);
  assign in_fence  = is_wrfence(meta_in);
  assign acc_wr    = accept && !in_fence && alloc[DEPTH_BASE2];
  assign acc_fence = accept && in_fence;
  assign lat_load  = ASE_CNT_W'(LAT_MIN) + (lfsr_low[ASE_CNT_W-1:0] & LAT_MASK);

  // The fence leaves one idle output cycle after the last older response.
  assign fence_fire = (state == ST_FENCE_DRAIN) && (occ == '0) && !resp_valid_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_NORMAL;
      occ            <= '0;
      fence_meta     <= '0;
      resp_meta_out  <= '0;
      resp_valid_out <= 1'b0;
      resp_is_fence  <= 1'b0;
      overflow       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      resp_valid_out <= 1'b0;
      resp_is_fence  <= 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
        if (slots[i].valid && (slots[i].countdown != '0)) begin
          slots[i].countdown <= slots[i].countdown - 1'b1;
        end
      end

      if (win_found) begin
        slots[win_idx].valid <= 1'b0;
        resp_meta_out        <= slots[win_idx].meta;
        resp_valid_out       <= 1'b1;
      end

      if (acc_wr) begin
        slots[alloc_idx].valid     <= 1'b1;
        slots[alloc_idx].meta      <= meta_in;
        slots[alloc_idx].countdown <= lat_load;
      end

      if (write_en && !accept) overflow <= 1'b1;

      occ <= occ + OCC_W'(acc_wr) - OCC_W'(win_found);

      case (state)
        ST_NORMAL: begin
          if (acc_fence) begin
            state      <= ST_FENCE_DRAIN;
            fence_meta <= meta_in;
          end
        end
        ST_FENCE_DRAIN: begin
          if (fence_fire) begin
            state          <= ST_NORMAL;
            resp_meta_out  <= fence_meta;
            resp_valid_out <= 1'b1;
            resp_is_fence  <= 1'b1;
          end
        end
        default: state <= ST_NORMAL;
      endcase
    end
  end

  assign full  = (state == ST_FENCE_DRAIN) || (occ >= OCC_W'(FULL_THRESH));
  assign empty = (occ == '0) && (state == ST_NORMAL);
  assign count = 32'(occ) + 32'(state == ST_FENCE_DRAIN);

endmodule

// File: tb/tb_wrresp_latency_channel.sv
// tb/tb_wrresp_latency_channel.sv - directed checks for the write-response latency channel
module tb_wrresp_latency_channel;
  import ase_pkg::*;

  localparam int HW = ASE_HDR_W;
  localparam int NLOG = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency instance (L = 4)
  logic          a_rst = 1'b1;
  logic          a_write_en = 1'b0;
  logic [HW-1:0] a_meta = '0;
  logic          a_full, a_resp_valid, a_resp_fence, a_empty, a_overflow;
  logic [HW-1:0] a_resp_meta;
  logic [31:0]   a_count;

  // Long random-latency instance (L = 32..39)
  logic          b_rst = 1'b1;
  logic          b_write_en = 1'b0;
  logic [HW-1:0] b_meta = '0;
  logic          b_full, b_resp_valid, b_resp_fence, b_empty, b_overflow;
  logic [HW-1:0] b_resp_meta;
  logic [31:0]   b_count;

  wrresp_latency_channel #(
    .HDR_WIDTH(HW), .DEPTH_BASE2(4), .FULL_THRESH(14),
    .LAT_MIN(4), .LAT_RANGE_BASE2(0), .LFSR_SEED(32'h1)
  ) dut_a (
    .clk(clk), .rst(a_rst), .meta_in(a_meta), .write_en(a_write_en),
    .full(a_full), .resp_meta_out(a_resp_meta), .resp_valid_out(a_resp_valid),
    .resp_is_fence(a_resp_fence), .empty(a_empty), .overflow(a_overflow), .count(a_count)
  );

  wrresp_latency_channel #(
    .HDR_WIDTH(HW), .DEPTH_BASE2(4), .FULL_THRESH(14),
    .LAT_MIN(32), .LAT_RANGE_BASE2(3), .LFSR_SEED(32'h1)
  ) dut_b (
    .clk(clk), .rst(b_rst), .meta_in(b_meta), .write_en(b_write_en),
    .full(b_full), .resp_meta_out(b_resp_meta), .resp_valid_out(b_resp_valid),
    .resp_is_fence(b_resp_fence), .empty(b_empty), .overflow(b_overflow), .count(b_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk(input logic [3:0] ty, input logic [15:0] md);
    logic [HW-1:0] m;
    m = '0;
    m[TX_META_TYPE_HI:TX_META_TYPE_LO] = ty;
    m[47:32] = ~md;
    m[15:0]  = md;
    return m;
  endfunction

  int ret_cnt [512];
  int nret = 0;
  int nfence = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (b_resp_valid) begin
      ret_cnt[b_resp_meta[8:0]]++;
      nret++;
      if (b_resp_fence) nfence++;
    end
  endtask

  logic          st_en  [NLOG];
  logic          st_rst [NLOG];
  logic [HW-1:0] st_meta[NLOG];
  logic          lg_v [NLOG], lg_f [NLOG], lg_full [NLOG], lg_empty [NLOG], lg_ov [NLOG];
  logic [HW-1:0] lg_meta [NLOG];
  logic [31:0]   lg_cnt [NLOG];

  task automatic clr_stim();
    for (int c = 0; c < NLOG; c++) begin
      st_en[c] = 1'b0; st_rst[c] = 1'b0; st_meta[c] = '0;
    end
  endtask

  // Cycle 0 is the first cycle with reset released.
  task automatic run_a(input int n);
    a_rst = 1'b1;
    tick(); tick();
    for (int c = 0; c < n; c++) begin
      a_rst = st_rst[c]; a_write_en = st_en[c]; a_meta = st_meta[c];
      lg_v[c] = a_resp_valid; lg_f[c] = a_resp_fence; lg_meta[c] = a_resp_meta;
      lg_full[c] = a_full; lg_empty[c] = a_empty; lg_ov[c] = a_overflow; lg_cnt[c] = a_count;
      tick();
    end
    a_rst = 1'b0; a_write_en = 1'b0;
  endtask

  initial begin
    int sent;
    int bad_ret;
    logic any_v;

    // Single write at cycle 10, L = 4 -> response in cycle 16
    clr_stim();
    st_en[10] = 1'b1; st_meta[10] = mk(4'h0, 16'h0011);
    run_a(24);
    check("rst_valid", 64'(lg_v[0]), 64'd0);
    check("rst_fence", 64'(lg_f[0]), 64'd0);
    check("rst_full", 64'(lg_full[0]), 64'd0);
    check("rst_empty", 64'(lg_empty[0]), 64'd1);
    check("rst_overflow", 64'(lg_ov[0]), 64'd0);
    check("rst_count", 64'(lg_cnt[0]), 64'd0);
    check("rst_meta", 64'(lg_meta[0]), 64'd0);
    check("one_cnt_c11", 64'(lg_cnt[11]), 64'd1);
    check("one_empty_c11", 64'(lg_empty[11]), 64'd0);
    check("one_v_c15", 64'(lg_v[15]), 64'd0);
    check("one_v_c16", 64'(lg_v[16]), 64'd1);
    check("one_meta_c16", 64'(lg_meta[16]), 64'(mk(4'h0, 16'h0011)));
    check("one_fence_c16", 64'(lg_f[16]), 64'd0);
    check("one_v_c17", 64'(lg_v[17]), 64'd0);
    check("one_cnt_c16", 64'(lg_cnt[16]), 64'd0);

    // Back-to-back writes 10..13 -> responses 16..19 in order
    clr_stim();
    for (int k = 0; k < 4; k++) begin
      st_en[10+k] = 1'b1; st_meta[10+k] = mk(4'h0, 16'h00A0 + 16'(k));
    end
    run_a(24);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b_v_c%0d", 16+k), 64'(lg_v[16+k]), 64'd1);
      check($sformatf("b2b_meta_c%0d", 16+k), 64'(lg_meta[16+k]), 64'(mk(4'h0, 16'h00A0 + 16'(k))));
    end
    check("b2b_v_c20", 64'(lg_v[20]), 64'd0);

    // Writes 10, 11 then WrFence at 12 -> fence response at 19
    clr_stim();
    st_en[10] = 1'b1; st_meta[10] = mk(4'h0, 16'h00B0);
    st_en[11] = 1'b1; st_meta[11] = mk(4'h0, 16'h00B1);
    st_en[12] = 1'b1; st_meta[12] = mk(ASE_TX1_WRFENCE, 16'h00FE);
    run_a(26);
    check("fen_full_c12", 64'(lg_full[12]), 64'd0);
    check("fen_full_c13", 64'(lg_full[13]), 64'd1);
    check("fen_cnt_c13", 64'(lg_cnt[13]), 64'd3);
    check("fen_meta_c16", 64'(lg_meta[16]), 64'(mk(4'h0, 16'h00B0)));
    check("fen_v_c17", 64'(lg_v[17]), 64'd1);
    check("fen_meta_c17", 64'(lg_meta[17]), 64'(mk(4'h0, 16'h00B1)));
    check("fen_f_c17", 64'(lg_f[17]), 64'd0);
    check("fen_v_c18", 64'(lg_v[18]), 64'd0);
    check("fen_full_c18", 64'(lg_full[18]), 64'd1);
    check("fen_v_c19", 64'(lg_v[19]), 64'd1);
    check("fen_f_c19", 64'(lg_f[19]), 64'd1);
    check("fen_meta_c19", 64'(lg_meta[19]), 64'(mk(ASE_TX1_WRFENCE, 16'h00FE)));
    check("fen_full_c19", 64'(lg_full[19]), 64'd0);
    check("fen_empty_c19", 64'(lg_empty[19]), 64'd1);

    // Fence on empty table at 5 -> response at 7; write at 6 dropped
    clr_stim();
    st_en[5] = 1'b1; st_meta[5] = mk(ASE_TX1_WRFENCE, 16'h00F5);
    st_en[6] = 1'b1; st_meta[6] = mk(4'h0, 16'h0066);
    run_a(16);
    check("efen_cnt_c6", 64'(lg_cnt[6]), 64'd1);
    check("efen_full_c6", 64'(lg_full[6]), 64'd1);
    check("efen_ov_c6", 64'(lg_ov[6]), 64'd0);
    check("efen_v_c7", 64'(lg_v[7]), 64'd1);
    check("efen_f_c7", 64'(lg_f[7]), 64'd1);
    check("efen_meta_c7", 64'(lg_meta[7]), 64'(mk(ASE_TX1_WRFENCE, 16'h00F5)));
    check("efen_ov_c7", 64'(lg_ov[7]), 64'd1);
    check("efen_full_c7", 64'(lg_full[7]), 64'd0);
    check("efen_cnt_c7", 64'(lg_cnt[7]), 64'd0);
    check("efen_v_c12", 64'(lg_v[12]), 64'd0);
    check("efen_ov_c15", 64'(lg_ov[15]), 64'd1);

    // Reset at 12 with three slots and a fence pending
    clr_stim();
    for (int k = 0; k < 3; k++) begin
      st_en[8+k] = 1'b1; st_meta[8+k] = mk(4'h0, 16'h00C0 + 16'(k));
    end
    st_en[11] = 1'b1; st_meta[11] = mk(ASE_TX1_WRFENCE, 16'h00CF);
    st_rst[12] = 1'b1;
    run_a(41);
    check("rst_mid_cnt_c12", 64'(lg_cnt[12]), 64'd4);
    check("rst_mid_full_c12", 64'(lg_full[12]), 64'd1);
    check("rst_mid_cnt_c13", 64'(lg_cnt[13]), 64'd0);
    check("rst_mid_empty_c13", 64'(lg_empty[13]), 64'd1);
    check("rst_mid_full_c13", 64'(lg_full[13]), 64'd0);
    any_v = 1'b0;
    for (int c = 13; c < 41; c++) any_v = any_v | lg_v[c];
    check("rst_mid_no_resp", 64'(any_v), 64'd0);

    // Fill all 16 slots ignoring full, then a 17th write
    foreach (ret_cnt[i]) ret_cnt[i] = 0;
    nret = 0; nfence = 0;
    b_rst = 1'b1; tick(); tick(); b_rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b_write_en = 1'b1; b_meta = mk(4'h0, 16'h0100 + 16'(i));
      if (i == 13) check("fill_full_occ13", 64'(b_full), 64'd0);
      if (i == 14) check("fill_full_occ14", 64'(b_full), 64'd1);
      if (i == 16) begin
        check("fill_cnt_16", 64'(b_count), 64'd16);
        check("fill_ov_before", 64'(b_overflow), 64'd0);
      end
      tick();
    end
    b_write_en = 1'b0;
    check("fill_ov_after", 64'(b_overflow), 64'd1);
    for (int c = 0; c < 80; c++) tick();
    check("fill_nresp", 64'(nret), 64'd16);
    check("fill_17th_absent", 64'(ret_cnt[9'h110]), 64'd0);
    check("fill_first_once", 64'(ret_cnt[9'h100]), 64'd1);
    check("fill_ov_sticky", 64'(b_overflow), 64'd1);
    check("fill_empty_end", 64'(b_empty), 64'd1);

    // 200 writes honouring full; each mdata must come back exactly once
    foreach (ret_cnt[i]) ret_cnt[i] = 0;
    nret = 0; nfence = 0; sent = 0;
    b_rst = 1'b1; tick(); tick(); b_rst = 1'b0;
    for (int c = 0; c < 4000 && !(sent == 200 && nret == 200); c++) begin
      if (sent < 200 && !b_full && $urandom_range(0, 3) != 0) begin
        b_write_en = 1'b1; b_meta = mk(4'h0, 16'(sent)); sent++;
      end else begin
        b_write_en = 1'b0;
      end
      tick();
    end
    b_write_en = 1'b0;
    bad_ret = 0;
    for (int i = 0; i < 200; i++) if (ret_cnt[i] != 1) bad_ret++;
    check("rnd_sent", 64'(sent), 64'd200);
    check("rnd_nresp", 64'(nret), 64'd200);
    check("rnd_each_once", 64'(bad_ret), 64'd0);
    check("rnd_no_fence", 64'(nfence), 64'd0);
    check("rnd_no_overflow", 64'(b_overflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
